// File: rtl/display_scan_pkg.sv
// -----------------------------------------------------------------------------
// display_scan_pkg
//
// Purpose:
//   Shared constants for the multiplexed 7-segment scan controller.
//   - The code that blanks the shared decoder.
//   - The default slot timing.
//   - The two slot phases of the scan.
//
// Contents:
//   NOTA_APAGADA  - 4-bit code that the decoder renders as all segments off.
//   PRESC_PADRAO  - default clock cycles per digit slot.
//   GAP_PADRAO    - default blanked cycles at the start of each slot.
//   APAGA/ACENDE  - slot phase encodings (anodes off / digit lit).
//   digito_nulo() - true when a BCD nibble is zero.
// -----------------------------------------------------------------------------
package display_scan_pkg;

    localparam logic [3:0] NOTA_APAGADA = 4'hF;

    localparam int PRESC_PADRAO = 50000;
    localparam int GAP_PADRAO   = 2;

    // Slot phases. Kept as plain constants so that older blocks sharing this
    // package can compare against them without enum casts.
    localparam logic [0:0] APAGA  = 1'b0;
    localparam logic [0:0] ACENDE = 1'b1;

    function automatic logic digito_nulo(input logic [3:0] d);
        return (d == 4'h0);
    endfunction

endpackage

// File: rtl/display_scan_contador.sv
// -----------------------------------------------------------------------------
// contador_varredura
//
// Purpose:
//   Generates the scan position for the display:
//   - The slot counter (cnt).
//   - The digit index (idx).
//   - The end-of-frame strobe.
//   The next-state values are exported so that the parent can register its
//   outputs in the same cycle that cnt/idx take those values.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   cnt_next   out  slot counter value for the next cycle
//   idx_next   out  digit index value for the next cycle
//   fim_quadro out  combinational: current cycle is the last of the frame
//   frame      out  registered one-cycle pulse aligned with the last cycle
//                   of the last digit's slot
// -----------------------------------------------------------------------------
module contador_varredura #(
    parameter int N_DIG = 4,
    parameter int PRESC = 50000,
    parameter int CW    = (PRESC > 1) ? $clog2(PRESC) : 1,
    parameter int IW    = (N_DIG > 1) ? $clog2(N_DIG) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] cnt_next,
    output logic [IW-1:0] idx_next,
    output logic          fim_quadro,
    output logic          frame
);

    localparam logic [CW-1:0] CNT_MAX = CW'(PRESC - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(N_DIG - 1);

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;

    // Advance within the slot. At the end of a slot, restart the counter and
    // move to the next digit, wrapping after the last one.
    always_comb begin
        cnt_next = cnt + CW'(1);
        idx_next = idx;
        if (cnt == CNT_MAX) begin
            cnt_next = '0;
            idx_next = (idx == IDX_MAX) ? '0 : idx + IW'(1);
        end
    end

    assign fim_quadro = (cnt == CNT_MAX) && (idx == IDX_MAX);

    // frame is computed from the next position so that, once registered, it
    // is high exactly while cnt/idx sit on the final cycle of the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            idx   <= '0;
            frame <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            idx   <= idx_next;
            frame <= (cnt_next == CNT_MAX) && (idx_next == IDX_MAX);
        end
    end

endmodule

// File: rtl/display_scan.sv
// -----------------------------------------------------------------------------
// display_scan
//
// Purpose:
//   Time-multiplexed scan controller for an N_DIG-digit common-anode
//   7-segment display that shares one BCD-to-segment decoder.
//   - Holds a double-buffered BCD value (shadow -> ativo).
//   - Commits the buffer only at frame end, so the display never tears.
//   - Blanks the anodes for GAP cycles at each slot start (anti-ghosting).
//   - Optionally suppresses leading zeros.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous reset, active-high
//   load      in   load request, honoured only while ready=1
//   dado      in   4*N_DIG BCD digits, dado[3:0] is the least significant
//   blank_lz  in   leading-zero suppression enable, sampled every cycle
//   ready     out  shadow register free to accept a load
//   nota      out  code to the shared decoder, 4'hF = blank
//   anodo     out  active-low digit enables, one-hot-low or all ones
//   frame     out  one-cycle pulse on the last cycle of the last digit slot
// -----------------------------------------------------------------------------
module display_scan
    import display_scan_pkg::*;
#(
    parameter int N_DIG = 4,
    parameter int PRESC = PRESC_PADRAO,
    parameter int GAP   = GAP_PADRAO
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [4*N_DIG-1:0] dado,
    input  logic               blank_lz,
    output logic               ready,
    output logic [3:0]         nota,
    output logic [N_DIG-1:0]   anodo,
    output logic               frame
);

    localparam int CW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [N_DIG-1:0] UM = N_DIG'(1);

    logic [4*N_DIG-1:0] shadow;
    logic [4*N_DIG-1:0] ativo;
    logic               pend;

    logic [4*N_DIG-1:0] shadow_next;
    logic [4*N_DIG-1:0] ativo_next;
    logic               pend_next;

    logic [CW-1:0]      cnt_next;
    logic [IW-1:0]      idx_next;
    logic               fim_quadro;

    logic [0:0]         fase_next;
    logic [N_DIG-1:0]   zero_ate_topo;
    logic [3:0]         digito_sel;
    logic               suprime_sel;

    contador_varredura #(
        .N_DIG (N_DIG),
        .PRESC (PRESC),
        .CW    (CW),
        .IW    (IW)
    ) u_contador (
        .clk        (clk),
        .rst        (rst),
        .cnt_next   (cnt_next),
        .idx_next   (idx_next),
        .fim_quadro (fim_quadro),
        .frame      (frame)
    );

    // Double buffer.
    // - The commit looks at pend as it stood at the start of the cycle.
    // - A load that lands on the frame-end cycle (only possible while nothing
    //   is pending) is therefore held for the following frame end.
    always_comb begin
        shadow_next = shadow;
        ativo_next  = ativo;
        pend_next   = pend;
        if (fim_quadro && pend) begin
            ativo_next = shadow;
            pend_next  = 1'b0;
        end
        if (load && ready) begin
            shadow_next = dado;
            pend_next   = 1'b1;
        end
    end

    // For every digit position, flag whether it and everything more
    // significant are zero; that is what makes a zero a "leading" one.
    always_comb begin
        zero_ate_topo = '0;
        for (int i = 0; i < N_DIG; i++) begin
            zero_ate_topo[i] = ((ativo >> (4 * i)) == '0);
        end
    end

    // Select the digit that will be lit next cycle and decide whether it is
    // suppressed. Digit 0 is never suppressed, so zero still shows as "0".
    always_comb begin
        digito_sel  = 4'h0;
        suprime_sel = 1'b0;
        for (int i = 0; i < N_DIG; i++) begin
            if (idx_next == IW'(i)) begin
                digito_sel  = ativo[4*i +: 4];
                suprime_sel = blank_lz && (i != 0) && zero_ate_topo[i];
            end
        end
    end

    assign fase_next = (cnt_next < CW'(GAP)) ? APAGA : ACENDE;

    // Registered outputs are driven from the next scan position, so they line
    // up with cnt/idx in the same cycle. The commit happens on a slot
    // boundary, which always starts with GAP >= 1 blank cycles, so using the
    // pre-commit ativo here never shows a stale digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
            ativo  <= '0;
            pend   <= 1'b0;
            ready  <= 1'b1;
            nota   <= NOTA_APAGADA;
            anodo  <= '1;
        end else begin
            shadow <= shadow_next;
            ativo  <= ativo_next;
            pend   <= pend_next;
            ready  <= !pend_next;
            if (fase_next == ACENDE) begin
                anodo <= ~(UM << idx_next);
                if (suprime_sel && digito_nulo(digito_sel)) begin
                    nota <= NOTA_APAGADA;
                end else begin
                    nota <= digito_sel;
                end
            end else begin
                anodo <= '1;
                nota  <= NOTA_APAGADA;
            end
        end
    end

endmodule
